// File: rtl/round_referee_if.sv
// Play-field signals shared between the game state machine / bike logic (master)
// and the round referee (slave).
interface round_referee_if #(
  parameter int SCORE_W = 3
);
  logic [2:0]         Game_State;
  logic               frame_tick;
  logic               Blue_Crash;
  logic               Red_Crash;
  logic               Reset_Round;
  logic               Blue_W;
  logic               Red_W;
  logic               freeze;
  logic [SCORE_W-1:0] blue_score;
  logic [SCORE_W-1:0] red_score;
  logic [1:0]         round_result;

  modport master (
    output Game_State, frame_tick, Blue_Crash, Red_Crash,
    input  Reset_Round, Blue_W, Red_W, freeze, blue_score, red_score, round_result
  );

  modport slave (
    input  Game_State, frame_tick, Blue_Crash, Red_Crash,
    output Reset_Round, Blue_W, Red_W, freeze, blue_score, red_score, round_result
  );
endinterface

// File: rtl/round_referee.sv
// Round referee: scores crashes during a round, freezes the bikes for a few frames,
// then tells the game state machine whether the round or the whole match is over.
module round_referee #(
  parameter int WIN_SCORE   = 3,
  parameter int SCORE_W     = 3,
  parameter int HOLD_FRAMES = 60
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Reset_Game,
  round_referee_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PLAY, HOLD, ROUND_END, MATCH_END} state_t;

  localparam int                 CNT_W     = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [2:0]         GS_MENU   = 3'd0;
  localparam logic [2:0]         GS_PLAY   = 3'd2;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] blue_q, blue_d, red_q, red_d;
  logic [1:0]         result_q, result_d;
  logic               reset_round_q, reset_round_d;
  logic               blue_w_q, blue_w_d;
  logic               red_w_q, red_w_d;
  logic               freeze_q, freeze_d;

  logic playing, menu, any_crash, match_won;

  assign playing   = (bus.Game_State == GS_PLAY);
  assign menu      = (bus.Game_State == GS_MENU);
  assign any_crash = bus.Blue_Crash | bus.Red_Crash;
  assign match_won = (blue_q == WIN) || (red_q == WIN);

  // State, datapath and registered outputs.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (Reset || Reset_Game) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      blue_q        <= '0;
      red_q         <= '0;
      result_q      <= 2'b00;
      reset_round_q <= 1'b0;
      blue_w_q      <= 1'b0;
      red_w_q       <= 1'b0;
      freeze_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      blue_q        <= blue_d;
      red_q         <= red_d;
      result_q      <= result_d;
      reset_round_q <= reset_round_d;
      blue_w_q      <= blue_w_d;
      red_w_q       <= red_w_d;
      freeze_q      <= freeze_d;
    end
  end

  // Next-state and score/counter update.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    blue_d   = blue_q;
    red_d    = red_q;
    result_d = result_q;

    if (menu) begin
      state_d  = IDLE;
      blue_d   = '0;
      red_d    = '0;
      result_d = 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (playing) state_d = PLAY;
        end
        PLAY: begin
          if (any_crash) begin
            // Loading the counter here means a tick on the crash cycle is not counted.
            cnt_d   = HOLD_LOAD;
            state_d = HOLD;
            unique case ({bus.Blue_Crash, bus.Red_Crash})
              2'b11: result_d = 2'b11;
              2'b10: begin
                result_d = 2'b10;
                if (red_q != SCORE_MAX) red_d = red_q + 1'b1;
              end
              default: begin
                result_d = 2'b01;
                if (blue_q != SCORE_MAX) blue_d = blue_q + 1'b1;
              end
            endcase
          end else if (!playing) begin
            state_d = IDLE;
          end
        end
        HOLD: begin
          if (!playing)              state_d = IDLE;
          else if (cnt_q == '0)      state_d = match_won ? MATCH_END : ROUND_END;
          else if (bus.frame_tick)   cnt_d   = cnt_q - 1'b1;
        end
        ROUND_END, MATCH_END: begin
          if (!playing) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the upcoming state and registered with it.
  always_comb begin
    freeze_d      = 1'b1;
    reset_round_d = 1'b0;
    blue_w_d      = 1'b0;
    red_w_d       = 1'b0;
    unique case (state_d)
      IDLE:      freeze_d      = !playing;
      PLAY:      freeze_d      = 1'b0;
      HOLD:      freeze_d      = 1'b1;
      ROUND_END: reset_round_d = 1'b1;
      MATCH_END: begin
        blue_w_d = (blue_d == WIN);
        red_w_d  = (blue_d != WIN);
      end
      default:   freeze_d      = 1'b1;
    endcase
  end

  assign bus.Reset_Round  = reset_round_q;
  assign bus.Blue_W       = blue_w_q;
  assign bus.Red_W        = red_w_q;
  assign bus.freeze       = freeze_q;
  assign bus.blue_score   = blue_q;
  assign bus.red_score    = red_q;
  assign bus.round_result = result_q;

endmodule

// File: tb/tb_round_referee.sv
// Randomised scoreboard bench for round_referee: a round-level reference model
// predicts every output cycle, a monitor compares one cycle after each edge.
module tb_round_referee;

  localparam int HF   = 2;
  localparam int WINS = 3;
  localparam int SW   = 3;
  localparam int SMAX = (1 << SW) - 1;

  // Round phases of the reference model.
  localparam int M_IDLE = 0, M_PLAY = 1, M_HOLD = 2, M_ROUND = 3, M_BLUE = 4, M_RED = 5;

  typedef struct packed {
    logic          rr;
    logic          bw;
    logic          rw;
    logic          fr;
    logic [SW-1:0] bs;
    logic [SW-1:0] rs;
    logic [1:0]    res;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_game = 1'b0;

  round_referee_if #(.SCORE_W(SW)) bus ();

  round_referee #(
    .WIN_SCORE  (WINS),
    .SCORE_W    (SW),
    .HOLD_FRAMES(HF)
  ) dut (
    .Clk       (clk),
    .Reset     (rst),
    .Reset_Game(rst_game),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int m_mode = M_IDLE;
  int m_left = 0;
  int m_blue = 0;
  int m_red  = 0;
  int m_res  = 0;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic apply(input logic [2:0] gs, input logic bc, input logic rc,
                       input logic tk, input logic r, input logic rg);
    obs_t e;
    @(negedge clk);
    bus.Game_State = gs;
    bus.Blue_Crash = bc;
    bus.Red_Crash  = rc;
    bus.frame_tick = tk;
    rst            = r;
    rst_game       = rg;

    if (r || rg) begin
      m_mode = M_IDLE; m_left = 0; m_blue = 0; m_red = 0; m_res = 0;
    end else if (gs == 3'd0) begin
      m_mode = M_IDLE; m_blue = 0; m_red = 0; m_res = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (gs == 3'd2) m_mode = M_PLAY;
        M_PLAY: begin
          if (bc || rc) begin
            if (bc && rc)  m_res = 3;
            else if (bc) begin m_res = 2; if (m_red  < SMAX) m_red++;  end
            else         begin m_res = 1; if (m_blue < SMAX) m_blue++; end
            m_left = HF;
            m_mode = M_HOLD;
          end else if (gs != 3'd2) m_mode = M_IDLE;
        end
        M_HOLD: begin
          if (gs != 3'd2)       m_mode = M_IDLE;
          else if (m_left == 0) m_mode = (m_blue == WINS) ? M_BLUE :
                                         (m_red == WINS)  ? M_RED  : M_ROUND;
          else if (tk)          m_left--;
        end
        default: if (gs != 3'd2) m_mode = M_IDLE;
      endcase
    end

    if (r || rg) begin
      e = '0;
    end else begin
      e.rr  = (m_mode == M_ROUND);
      e.bw  = (m_mode == M_BLUE);
      e.rw  = (m_mode == M_RED);
      e.fr  = (m_mode == M_PLAY) ? 1'b0 : (m_mode == M_IDLE) ? (gs != 3'd2) : 1'b1;
      e.bs  = SW'(m_blue);
      e.rs  = SW'(m_red);
      e.res = 2'(m_res);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input logic [2:0] gs, input int n);
    for (int i = 0; i < n; i++) apply(gs, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // A full round: start, crash, hold with ticks, linger, then pause.
  task automatic play_round(input logic bc, input logic rc);
    idle_cycles(3'd2, 2);
    apply(3'd2, bc, rc, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) apply(3'd2, 1'b0, 1'b0, logic'(i % 2), 1'b0, 1'b0);
    idle_cycles(3'd2, 2);
    idle_cycles(3'd1, 2);
  endtask

  // Monitor: one observation per clock, compared against the oldest prediction.
  initial begin
    obs_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{bus.Reset_Round, bus.Blue_W, bus.Red_W, bus.freeze,
                bus.blue_score, bus.red_score, bus.round_result};
        n_vec++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL outputs vec %0d: got rr/bw/rw/frz=%b%b%b%b blue=%0d red=%0d res=%b, expected rr/bw/rw/frz=%b%b%b%b blue=%0d red=%0d res=%b",
                   n_vec, got.rr, got.bw, got.rw, got.fr, got.bs, got.rs, got.res,
                   e.rr, e.bw, e.rw, e.fr, e.bs, e.rs, e.res);
        end
      end
    end
  end

  initial begin
    logic [2:0] gs;
    int         r;
    bus.Game_State = 3'd1;
    bus.Blue_Crash = 1'b0;
    bus.Red_Crash  = 1'b0;
    bus.frame_tick = 1'b0;

    // Reset, then start play.
    apply(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles(3'd1, 1);
    idle_cycles(3'd2, 3);
    idle_cycles(3'd1, 1);

    // Blue takes a round, a draw, blue takes two more and the match.
    play_round(1'b0, 1'b1);
    play_round(1'b1, 1'b1);
    play_round(1'b0, 1'b1);
    idle_cycles(3'd2, 2);
    apply(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) apply(3'd2, 1'b0, 1'b0, logic'(i % 2), 1'b0, 1'b0);
    idle_cycles(3'd2, 3);
    idle_cycles(3'd3, 2);

    // Menu clears the board; crashes in IDLE and HOLD are ignored.
    idle_cycles(3'd0, 2);
    apply(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(3'd2, 1);
    apply(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Match reset in the middle of a hold.
    apply(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(3'd2, 8);

    // Hold aborted by leaving the round keeps the score.
    apply(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(3'd1, 2);

    // Random play.
    gs = 3'd2;
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 99) < 8) begin
        r  = $urandom_range(0, 99);
        gs = (r < 4) ? 3'd0 : (r < 40) ? 3'd1 : (r < 50) ? 3'(3 + $urandom_range(0, 1)) : 3'd2;
      end
      apply(gs,
            logic'($urandom_range(0, 11) == 0),
            logic'($urandom_range(0, 11) == 0),
            logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 1499) == 0),
            logic'($urandom_range(0, 499) == 0));
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/round_referee.md
Name: round_referee

Overview:
- Downstream of the game state machine during play; feeds its round/match inputs.
- Watches bike crash flags while Game_State is Round_Started and tracks per-player round scores.
- Holds a short crash freeze, then asserts Reset_Round, Blue_W or Red_W back to the game state machine.
- Exports scores and last-round result to the sprite/text renderer.

Parameters:
WIN_SCORE, 3, rounds needed to win the match (1..2^SCORE_W-1)
SCORE_W, 3, width of each score counter
HOLD_FRAMES, 60, frame_tick count for which the bikes stay frozen after a crash

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Reset_Game  in  1  synchronous match reset; same effect as Reset
Game_State  in  3  encoding: 0 Menu, 1 Round_Paused, 2 Round_Started, 3 Blue_Wins, 4 Red_Wins
frame_tick  in  1  one-cycle pulse per video frame
Blue_Crash  in  1  blue bike hit a trail/wall this cycle (level or pulse)
Red_Crash  in  1  red bike hit a trail/wall this cycle
Reset_Round  out  1  round over, match continues
Blue_W  out  1  blue has won the match
Red_W  out  1  red has won the match
freeze  out  1  bikes must not advance
blue_score  out  SCORE_W  blue rounds won
red_score  out  SCORE_W  red rounds won
round_result  out  2  00 none, 01 blue took round, 10 red took round, 11 draw

Behaviour:
- Reset or Reset_Game (either high at a rising edge):
  - state IDLE; scores 0; round_result 00.
  - Reset_Round, Blue_W, Red_W and freeze all 0; hold counter 0.
  - Overrides every other input that cycle, including mid-hold.
- Game_State == 0 (Menu) in any state: scores and round_result clear to 0 next cycle; state forced to IDLE.
- All outputs are registered: one cycle of latency from inputs.
- FSM states: IDLE, PLAY, HOLD, ROUND_END, MATCH_END.
- IDLE:
  - Outputs 0, except freeze = 1 whenever Game_State != 2.
  - Go to PLAY when Game_State == 2.
- PLAY:
  - freeze = 0.
  - Crash flags are sampled every cycle; they are ignored in all other states.
  - Blue_Crash & Red_Crash: draw; round_result 11; no score change.
  - Blue_Crash only: red_score +1; round_result 10.
  - Red_Crash only: blue_score +1; round_result 01.
  - Any crash: load hold counter with HOLD_FRAMES and go to HOLD.
  - Game_State != 2 without a crash: abort to IDLE; scores unchanged.
- HOLD:
  - freeze = 1.
  - Counter == 0: leave next cycle.
    - If blue_score == WIN_SCORE or red_score == WIN_SCORE, go to MATCH_END.
    - Otherwise go to ROUND_END.
  - Counter != 0: decrement on frame_tick.
  - A frame_tick in the same cycle as the crash is not counted.
  - HOLD_FRAMES = 0 gives exactly one HOLD cycle.
  - Game_State leaving 2 during HOLD: abort to IDLE; the score update is kept.
- ROUND_END:
  - Reset_Round = 1 and freeze = 1, held while Game_State == 2.
  - When Game_State != 2, go to IDLE and drop Reset_Round that same registered cycle.
- MATCH_END:
  - Blue_W = 1 if blue_score == WIN_SCORE, else Red_W = 1; never both.
  - Output held until Game_State != 2, then go to IDLE.
  - Scores stay on display until Menu or Reset_Game.
- Scores saturate at 2^SCORE_W-1.
  - A draw cannot produce two winners because only one score changes per crash.
- Reset_Round, Blue_W and Red_W are mutually exclusive at all times.
- Hold counter width is $clog2(HOLD_FRAMES+1), minimum 1.

Test Plan:
- Reset high 2 cycles, then Game_State = 2 → IDLE→PLAY; freeze 1→0; scores 0; all flags 0.
- HOLD_FRAMES = 2, PLAY, Red_Crash pulse →
  - blue_score = 1, round_result = 01, freeze = 1.
  - Reset_Round rises exactly 1 cycle after the 2nd subsequent frame_tick.
  - Game_State → 1: Reset_Round falls next cycle.
- Blue_Crash and Red_Crash in the same cycle → round_result = 11; scores unchanged; Reset_Round after the hold.
- WIN_SCORE = 3, blue_score = 2, Red_Crash → blue_score = 3; after the hold Blue_W = 1, Red_W = 0, Reset_Round = 0; Blue_W is held until Game_State = 3, then 0.
- Crash during HOLD or IDLE → no score change.
- Game_State → 0 after a win → scores 0, round_result 00.
- Reset_Game asserted mid-HOLD → state IDLE, freeze = 0 next cycle, counter 0, scores 0, no Reset_Round/Blue_W/Red_W pulse afterwards.
